// File: rtl/exec_unit_if.sv
// Request/write-back bundle between the operand source and exec_unit; exec_unit takes the slave side.
interface exec_unit_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             START;
  logic [2:0]       OP;
  logic [AW-1:0]    DST;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic             LD;
  logic [AW-1:0]    DR;
  logic [WIDTH-1:0] D_OUT;
  logic             Z;
  logic             C;

  modport master (output START, OP, DST, A, B,
                  input  BUSY, DONE, LD, DR, D_OUT, Z, C);
  modport slave  (input  START, OP, DST, A, B,
                  output BUSY, DONE, LD, DR, D_OUT, Z, C);
endinterface

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: ALU ops E=1, shifts E=max(1,count), MUL (EXU_MUL_EN) E=8; WRITE pulse one cycle later.
// No backpressure: START is accepted only in IDLE; requests while BUSY or in WRITE are dropped, not queued.
module exec_unit #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  exec_unit_if.slave  io
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRITE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic [AW-1:0]    dr_q, dr_d;
  logic             z_q, z_d;
  logic             c_q, c_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             exec_last;
  logic             wr_en;

`ifdef EXU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      d_out_q <= '0;
      dr_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
`ifdef EXU_MUL_EN
      acc_q   <= '0;
      mcand_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      dr_q    <= dr_d;
      z_q     <= z_d;
      c_q     <= c_d;
`ifdef EXU_MUL_EN
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
`endif
    end
  end

  // Datapath: result of the current EXEC cycle and whether it is the final one.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    dr_d    = dr_q;
    z_d     = z_q;
    c_d     = c_q;
`ifdef EXU_MUL_EN
    acc_d   = acc_q;
    mcand_d = mcand_q;
    prod    = acc_q + (b_q[0] ? mcand_q : '0);
`endif
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    res       = '0;
    res_c     = 1'b0;
    exec_last = 1'b1;
    wr_en     = 1'b1;

    case (op_q)
      OP_ADD: begin res = sum[WIDTH-1:0];  res_c = sum[WIDTH];  end
      OP_SUB: begin res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_SHL: begin
        res = a_q;
        if (cnt_q != 3'd0) begin
          res       = {a_q[WIDTH-2:0], 1'b0};
          res_c     = a_q[WIDTH-1];
          exec_last = (cnt_q == 3'd1);
        end
      end
      OP_SHR: begin
        res = a_q;
        if (cnt_q != 3'd0) begin
          res       = {1'b0, a_q[WIDTH-1:1]};
          res_c     = a_q[0];
          exec_last = (cnt_q == 3'd1);
        end
      end
      OP_MUL: begin
`ifdef EXU_MUL_EN
        res       = prod[WIDTH-1:0];
        res_c     = |prod[2*WIDTH-1:WIDTH];
        exec_last = (cnt_q == 3'd0);
`else
        wr_en     = 1'b0;
`endif
      end
    endcase

    if (state_q == S_IDLE && io.START) begin
      a_d   = io.A;
      b_d   = io.B;
      op_d  = io.OP;
      dst_d = io.DST;
      if (io.OP == OP_SHL || io.OP == OP_SHR)
        cnt_d = io.B[2:0];
      else if (io.OP == OP_MUL)
        cnt_d = 3'd7;
      else
        cnt_d = 3'd0;
`ifdef EXU_MUL_EN
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, io.A};
`endif
    end else if (state_q == S_EXEC) begin
      if ((op_q == OP_SHL || op_q == OP_SHR) && cnt_q != 3'd0) begin
        a_d   = res;
        cnt_d = cnt_q - 3'd1;
      end
`ifdef EXU_MUL_EN
      if (op_q == OP_MUL) begin
        acc_d   = prod;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q - 3'd1;
      end
`endif
      if (exec_last && wr_en) begin
        d_out_d = res;
        dr_d    = dst_q;
        z_d     = (res == '0);
        c_d     = res_c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (io.START) state_d = S_EXEC;
      S_EXEC:  if (exec_last) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.BUSY  = (state_q != S_IDLE);
    io.DONE  = (state_q == S_WRITE);
`ifdef EXU_MUL_EN
    io.LD    = (state_q == S_WRITE);
`else
    io.LD    = (state_q == S_WRITE) && (op_q != OP_MUL);
`endif
    io.DR    = dr_q;
    io.D_OUT = d_out_q;
    io.Z     = z_q;
    io.C     = c_q;
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: opcode table plus hand sequences for held START and mid-operation reset.
module tb_exec_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exec_unit_if #(.WIDTH(8), .AW(3)) bus ();

  exec_unit #(.WIDTH(8), .AW(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] dst;
    logic [7:0] dout;
    logic [2:0] dr;
    logic       z;
    logic       c;
    int         lat;
    int         ld;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issues one op at edge N and watches until BUSY drops; lat is j where DONE is seen in the cycle after edge N+j.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] dst, output int lat, output int ld_cnt,
                        output int busy_cnt, output logic [7:0] dout, output logic [2:0] dr,
                        output logic z, output logic c);
    bit seen;
    seen = 0; lat = -1; ld_cnt = 0; busy_cnt = 0; dout = 'x; dr = 'x; z = 'x; c = 'x;
    @(negedge clk);
    bus.START = 1'b1; bus.OP = op; bus.A = a; bus.B = b; bus.DST = dst;
    @(posedge clk);
    #1 bus.START = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.BUSY) busy_cnt++;
      if (bus.LD) ld_cnt++;
      if (bus.DONE && !seen) begin
        seen = 1; lat = j;
        dout = bus.D_OUT; dr = bus.DR; z = bus.Z; c = bus.C;
      end
      if (seen && !bus.BUSY) break;
    end
  endtask

  initial begin
    int lat, ldc, busyc, ld_hold;
    logic [7:0] dout, dout_at_ld;
    logic [2:0] dr;
    logic z, c;
    bit seen;

    checks = 0; failures = 0;
    rst = 1'b1;
    bus.START = 1'b0; bus.OP = '0; bus.A = '0; bus.B = '0; bus.DST = '0;

    //           op    a      b      dst   dout   dr    z     c     lat ld
    vt[0]  = '{3'd0, 8'h7F, 8'h01, 3'd2, 8'h80, 3'd2, 1'b0, 1'b0, 1, 1};
    vt[1]  = '{3'd1, 8'h05, 8'h07, 3'd5, 8'hFE, 3'd5, 1'b0, 1'b1, 1, 1};
    vt[2]  = '{3'd4, 8'h3C, 8'h3C, 3'd1, 8'h00, 3'd1, 1'b1, 1'b0, 1, 1};
    vt[3]  = '{3'd5, 8'h81, 8'h01, 3'd3, 8'h02, 3'd3, 1'b0, 1'b1, 1, 1};
    vt[4]  = '{3'd6, 8'h81, 8'h03, 3'd4, 8'h10, 3'd4, 1'b0, 1'b0, 3, 1};
    vt[5]  = '{3'd5, 8'h5A, 8'h08, 3'd6, 8'h5A, 3'd6, 1'b0, 1'b0, 1, 1};
`ifdef EXU_MUL_EN
    vt[6]  = '{3'd7, 8'h12, 8'h10, 3'd7, 8'h20, 3'd7, 1'b0, 1'b1, 8, 1};
`else
    vt[6]  = '{3'd7, 8'h12, 8'h10, 3'd7, 8'h5A, 3'd6, 1'b0, 1'b0, 1, 0};
`endif
    vt[7]  = '{3'd2, 8'hF0, 8'h3C, 3'd0, 8'h30, 3'd0, 1'b0, 1'b0, 1, 1};
    vt[8]  = '{3'd3, 8'h00, 8'h00, 3'd1, 8'h00, 3'd1, 1'b1, 1'b0, 1, 1};
    vt[9]  = '{3'd0, 8'hFF, 8'h01, 3'd2, 8'h00, 3'd2, 1'b1, 1'b1, 1, 1};
    vt[10] = '{3'd5, 8'h03, 8'h07, 3'd5, 8'h80, 3'd5, 1'b0, 1'b1, 7, 1};
    vt[11] = '{3'd1, 8'h07, 8'h07, 3'd3, 8'h00, 3'd3, 1'b1, 1'b0, 1, 1};
`ifdef EXU_MUL_EN
    vt[12] = '{3'd7, 8'hFF, 8'hFF, 3'd4, 8'h01, 3'd4, 1'b0, 1'b1, 8, 1};
`else
    vt[12] = '{3'd7, 8'hFF, 8'hFF, 3'd4, 8'h00, 3'd3, 1'b1, 1'b0, 1, 0};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.BUSY, bus.DONE, bus.LD, bus.DR, bus.D_OUT, bus.Z, bus.C}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {bus.BUSY, bus.DONE, bus.LD, bus.DR, bus.D_OUT, bus.Z, bus.C}, '0);

    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].dst, lat, ldc, busyc, dout, dr, z, c);
      check($sformatf("v%0d_latency", i), lat, vt[i].lat);
      check($sformatf("v%0d_ld_pulses", i), ldc, vt[i].ld);
      check($sformatf("v%0d_busy_cycles", i), busyc, vt[i].lat + 1);
      check($sformatf("v%0d_d_out", i), dout, vt[i].dout);
      check($sformatf("v%0d_dr", i), dr, vt[i].dr);
      check($sformatf("v%0d_z", i), z, vt[i].z);
      check($sformatf("v%0d_c", i), c, vt[i].c);
    end

    // START held high with changing operands during a 7-cycle SHR: ignored until the cycle after WRITE.
    ld_hold = 0; dout_at_ld = 'x;
    @(negedge clk);
    bus.START = 1'b1; bus.OP = 3'd6; bus.A = 8'h80; bus.B = 8'h07; bus.DST = 3'd5;
    @(posedge clk);
    #1 bus.OP = 3'd0; bus.A = 8'h10; bus.B = 8'h20; bus.DST = 3'd6;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (bus.LD) begin ld_hold++; dout_at_ld = bus.D_OUT; end
    end
    check("hold_ld_pulses", ld_hold, 1);
    check("hold_shr_result", dout_at_ld, 8'h01);
    @(negedge clk);
    check("hold_idle_after_write", bus.BUSY, 1'b0);
    @(negedge clk);
    check("hold_accept_next", bus.BUSY, 1'b1);
    bus.START = 1'b0;
    seen = 0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      if (bus.DONE) begin
        seen = 1;
        check("hold_add_result", bus.D_OUT, 8'h30);
        check("hold_add_dr", bus.DR, 3'd6);
        check("hold_add_ld", bus.LD, 1'b1);
      end
    end
    check("hold_add_done_seen", seen, 1'b1);

    // Reset at edge N+4 of a 7-cycle shift aborts it with no write-back.
    @(negedge clk);
    bus.START = 1'b1; bus.OP = 3'd5; bus.A = 8'h01; bus.B = 8'h07; bus.DST = 3'd2;
    @(posedge clk);
    #1 bus.START = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {bus.BUSY, bus.DONE, bus.LD, bus.DR, bus.D_OUT, bus.Z, bus.C}, '0);
    rst = 1'b0;
    ldc = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.LD || bus.DONE || bus.BUSY) ldc++;
    end
    check("abort_no_activity", ldc, 0);
    run_op(3'd0, 8'h01, 8'h01, 3'd1, lat, ldc, busyc, dout, dr, z, c);
    check("after_abort_add_d_out", dout, 8'h02);
    check("after_abort_add_latency", lat, 1);
    check("after_abort_add_ld", ldc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Multi-cycle execute stage directly downstream of the 8-entry register file.
- Takes the two read operands, an opcode and a destination index.
- Produces the write-back data, destination index and load strobe that drive the register file's D_in, DR and LD inputs.
- Single-cycle logic/arithmetic ops plus iterative shifts and an 8x8 shift-add multiply, sequenced by a small FSM.

Parameters:
WIDTH, 8, datapath width; must be 8 (shift count uses 3 bits, multiply iterates WIDTH times)
AW, 3, destination-index width; matches the register file's 8 registers

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  request; sampled only in IDLE
OP  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
DST  input  AW  destination register index
A  input  WIDTH  operand A (from register file DATA_A)
B  input  WIDTH  operand B (from register file DATA_B)
BUSY  output  1  high in EXEC and WRITE
DONE  output  1  one-cycle completion pulse
LD  output  1  register-file load strobe
DR  output  AW  destination index for write-back
D_OUT  output  WIDTH  write-back data
Z  output  1  zero flag of last result
C  output  1  carry/borrow/shift-out/overflow flag of last result

Behaviour:
- Reset: state IDLE; BUSY=0, DONE=0, LD=0, DR=0, D_OUT=0x00, Z=0, C=0; internal counters cleared.
- FSM states: IDLE, EXEC, WRITE.
- IDLE:
  - START=1 at edge N latches A, B, OP, DST into internal registers and moves to EXEC.
  - START=0 holds IDLE.
- EXEC runs E cycles, then moves to WRITE:
  - ADD/SUB/AND/OR/XOR: E=1.
  - SHL/SHR: shift the working register one bit per cycle; E = max(1, B[2:0]); a count of 0 gives a result of A unchanged.
  - MUL: E=8. Each cycle: if multiplier LSB is 1, add the multiplicand into a 16-bit accumulator; multiplicand shifts left, multiplier shifts right.
- WRITE lasts exactly one cycle, then returns to IDLE.
  - Entry edge is N+E; D_OUT, DR, Z and C are registered at that edge.
  - LD=1 and DONE=1 for this cycle only; the register file captures at edge N+E+1.
- Outputs hold between operations: D_OUT, DR, Z and C keep their values until the next WRITE entry. LD and DONE are 0 outside WRITE.
- Arithmetic is mod 256.
- Flag C by opcode:
  - ADD: carry out of bit 7.
  - SUB: borrow (A<B unsigned).
  - AND/OR/XOR: 0.
  - SHL/SHR: last bit shifted out; 0 if count is 0.
  - MUL: 1 if the product's high byte is nonzero.
- Flag Z = (D_OUT == 0).
- START while BUSY=1 is ignored, with no queueing. START in the WRITE cycle is also ignored; earliest accepted START is the cycle after WRITE.
- Latched operands are used throughout: changes on A/B/OP/DST during EXEC have no effect.
- RESET mid-operation (any state) wins over everything. Next cycle is IDLE with all outputs at reset values; no LD pulse is issued for the aborted op.

Optional Feature:
- Macro EXU_MUL_EN.
- Defined: OP=7 performs the 8-cycle multiply as above.
- Undefined: no multiplier datapath or accumulator is synthesised. OP=7 takes E=1 and enters WRITE with LD=0 (no register-file write) and DONE=1. D_OUT, Z and C keep their previous values. All other opcodes are unaffected.

Test Plan:
- ADD A=0x7F B=0x01 DST=2, START at edge N -> LD=1/DONE=1 for the cycle after edge N+1; D_OUT=0x80, DR=2, Z=0, C=0; LD=0 thereafter.
- SUB A=0x05 B=0x07 DST=5 -> D_OUT=0xFE, C=1, Z=0; then XOR A=0x3C B=0x3C -> D_OUT=0x00, Z=1, C=0.
- SHL A=0x81 B=0x01 -> D_OUT=0x02, C=1, LD at cycle after N+1. SHR A=0x81 B=0x03 -> D_OUT=0x10, C=0, LD at cycle after N+3. SHL with B=0x08 (count 0) -> D_OUT=A, C=0, E=1.
- MUL A=0x12 B=0x10 DST=7 (EXU_MUL_EN defined) -> BUSY for 9 cycles; LD at cycle after N+8; D_OUT=0x20, C=1. Rebuild without the macro: same stimulus gives DONE at cycle after N+1, LD never 1, D_OUT unchanged.
- START held high with new operands during an active MUL -> ignored; exactly one LD pulse; a new op is accepted only the cycle after WRITE.
- RESET asserted at edge N+4 of a MUL -> IDLE next cycle, D_OUT=0x00, LD stays 0, no DONE pulse; a following ADD 0x01+0x01 completes normally with D_OUT=0x02.
